// File: rtl/step_pulse_gen.sv
// step_pulse_gen
//   Produces the single-cycle `step` qualifier used to gate loadable registers.
//   In single-step mode each debounced button press yields exactly one pulse.
//   In run mode a free-running divider yields one pulse every RUN_DIV cycles.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous, active-high reset
//   btn        in   raw pushbutton (asynchronous, bouncing), 1 = pressed
//   run_mode   in   raw slide switch (asynchronous), 1 = run, 0 = single-step
//   step       out  registered single-cycle step qualifier
//   btn_level  out  registered debounced button level
//   run_active out  synchronized run_mode
//   step_cnt   out  number of step pulses issued, wraps at 16 bits
//
// Parameters
//   DB_CYCLES  stable synchronized samples needed to accept a level change (>= 2)
//   RUN_DIV    step period in run mode, in clk cycles (>= 2)
module step_pulse_gen #(
  parameter int DB_CYCLES = 500000,
  parameter int RUN_DIV   = 10000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn,
  input  logic        run_mode,
  output logic        step,
  output logic        btn_level,
  output logic        run_active,
  output logic [15:0] step_cnt
);

  localparam int DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } db_state_e;

  // Two-flop synchronizers for the asynchronous inputs.
  logic btn_meta_q, btn_s_q;
  logic run_meta_q, run_s_q;

  db_state_e        state_q, state_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             step_q, step_d;
  logic             btn_level_q, btn_level_d;
  logic [15:0]      step_cnt_q, step_cnt_d;
  logic             press_evt;
  logic             div_wrap;

  always_comb begin
    state_d   = state_q;
    db_cnt_d  = db_cnt_q;
    press_evt = 1'b0;

    case (state_q)
      IDLE: begin
        if (btn_s_q) begin
          state_d  = WAIT_PRESS;
          db_cnt_d = '0;
        end
      end
      WAIT_PRESS: begin
        if (!btn_s_q) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = PRESSED;
          db_cnt_d  = '0;
          press_evt = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end
      PRESSED: begin
        if (!btn_s_q) begin
          state_d  = WAIT_RELEASE;
          db_cnt_d = '0;
        end
      end
      WAIT_RELEASE: begin
        if (btn_s_q) begin
          state_d  = PRESSED;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end
      default: begin
        state_d  = IDLE;
        db_cnt_d = '0;
      end
    endcase

    btn_level_d = (state_d == PRESSED) || (state_d == WAIT_RELEASE);

    // Divider only runs in run mode; leaving run mode discards the partial
    // period so the next run always starts from a full period.
    div_wrap = run_s_q && (div_cnt_q == DIV_LAST);
    if (!run_s_q) begin
      div_cnt_d = '0;
    end else if (div_wrap) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + DIV_ONE;
    end

    // Mode selects exactly one pulse source, so a press coinciding with a
    // wrap can never double up. The step_q term keeps pulses from touching
    // when a wrap and a press straddle a mode change.
    step_d     = (run_s_q ? div_wrap : press_evt) && !step_q;
    step_cnt_d = step_cnt_q + {15'd0, step_d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta_q  <= 1'b0;
      btn_s_q     <= 1'b0;
      run_meta_q  <= 1'b0;
      run_s_q     <= 1'b0;
      state_q     <= IDLE;
      db_cnt_q    <= '0;
      div_cnt_q   <= '0;
      step_q      <= 1'b0;
      btn_level_q <= 1'b0;
      step_cnt_q  <= '0;
    end else begin
      btn_meta_q  <= btn;
      btn_s_q     <= btn_meta_q;
      run_meta_q  <= run_mode;
      run_s_q     <= run_meta_q;
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      div_cnt_q   <= div_cnt_d;
      step_q      <= step_d;
      btn_level_q <= btn_level_d;
      step_cnt_q  <= step_cnt_d;
    end
  end

  assign step       = step_q;
  assign btn_level  = btn_level_q;
  assign run_active = run_s_q;
  assign step_cnt   = step_cnt_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen. Main instance uses DB_CYCLES=4,
// RUN_DIV=5; a second instance with RUN_DIV=2 on a faster clock covers the
// 16-bit step counter wrap. Edge numbers in the loops count rising edges
// from the first edge that samples the new input value.
module tb_step_pulse_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clk_w = 1'b0;
  always #5 clk = ~clk;
  always #1 clk_w = ~clk_w;

  logic        rst, btn, run_mode;
  logic        step, btn_level, run_active;
  logic [15:0] step_cnt;

  logic        rst_w, btn_w, run_mode_w;
  logic        step_w, btn_level_w, run_active_w;
  logic [15:0] step_cnt_w;

  step_pulse_gen #(.DB_CYCLES(4), .RUN_DIV(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn),
    .run_mode   (run_mode),
    .step       (step),
    .btn_level  (btn_level),
    .run_active (run_active),
    .step_cnt   (step_cnt)
  );

  step_pulse_gen #(.DB_CYCLES(4), .RUN_DIV(2)) dut_w (
    .clk        (clk_w),
    .rst        (rst_w),
    .btn        (btn_w),
    .run_mode   (run_mode_w),
    .step       (step_w),
    .btn_level  (btn_level_w),
    .run_active (run_active_w),
    .step_cnt   (step_cnt_w)
  );

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic [7:0]  exp_q[$];  // edge numbers where step is expected high

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns 1 when edge e is the next expected pulse edge, consuming it.
  function automatic logic pop_exp(input int e);
    if (exp_q.size() != 0 && exp_q[0] == 8'(e)) begin
      void'(exp_q.pop_front());
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst = 1'b1; btn = 1'b0; run_mode = 1'b0;
    rst_w = 1'b1; btn_w = 1'b0; run_mode_w = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_step", 16'(step), 16'd0);
    chk("rst_level", 16'(btn_level), 16'd0);
    chk("rst_run", 16'(run_active), 16'd0);
    chk("rst_cnt", step_cnt, 16'd0);
    rst = 1'b0;
    rst_w = 1'b0;

    // Clean press: pulse only after edge 7, level high from edge 7
    exp_q = '{8'd7};
    btn = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      chk("press_step", 16'(step), 16'(pop_exp(e)));
      chk("press_level", 16'(btn_level), 16'(e >= 7));
    end
    exp_cnt++;
    chk("press_cnt", step_cnt, exp_cnt);
    chk("press_q", 16'(exp_q.size()), 16'd0);

    // Release: level falls after edge 7, no pulse
    btn = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk("release_step", 16'(step), 16'd0);
      chk("release_level", 16'(btn_level), 16'(e < 7));
    end

    // Bounce 1,0,1,0 in runs of 3, then stable high from edge 13 -> pulse at 19
    exp_q = '{8'd19};
    for (int e = 1; e <= 30; e++) begin
      btn = (e <= 12) ? (((e - 1) / 3) % 2 == 0) : 1'b1;
      tick();
      chk("bounce_step", 16'(step), 16'(pop_exp(e)));
      chk("bounce_level", 16'(btn_level), 16'(e >= 19));
    end
    exp_cnt++;
    chk("bounce_cnt", step_cnt, exp_cnt);
    chk("bounce_q", 16'(exp_q.size()), 16'd0);

    // 3-cycle dropout while held: no second pulse, level stays high
    for (int e = 1; e <= 20; e++) begin
      btn = !(e >= 3 && e <= 5);
      tick();
      chk("dropout_step", 16'(step), 16'd0);
      chk("dropout_level", 16'(btn_level), 16'd1);
    end
    btn = 1'b0;
    repeat (12) tick();
    chk("dropout_cnt", step_cnt, exp_cnt);
    chk("dropout_idle_level", 16'(btn_level), 16'd0);

    // Run mode: pulses after 7,12,17,22,27; press from edge 14 adds none
    exp_q = '{8'd7, 8'd12, 8'd17, 8'd22, 8'd27};
    for (int e = 1; e <= 30; e++) begin
      run_mode = 1'b1;
      if (e >= 14) btn = 1'b1;
      tick();
      chk("run_step", 16'(step), 16'(pop_exp(e)));
      chk("run_active", 16'(run_active), 16'(e >= 2));
    end
    // div_cnt is 3 here; run_s stays high two more edges, so one more wrap at 32
    exp_q = '{8'd32};
    run_mode = 1'b0;
    btn = 1'b0;
    for (int e = 31; e <= 45; e++) begin
      tick();
      chk("runoff_step", 16'(step), 16'(pop_exp(e)));
      chk("runoff_active", 16'(run_active), 16'(e < 32));
    end
    exp_cnt = exp_cnt + 16'd6;
    chk("run_cnt", step_cnt, exp_cnt);
    chk("run_q", 16'(exp_q.size()), 16'd0);
    chk("run_div_idle", 16'(dut.div_cnt_q), 16'd0);
    chk("run_level", 16'(btn_level), 16'd0);

    // Mode switch: run_s drops while div_cnt = 3, then press -> only press pulse
    exp_q = '{8'd16};
    for (int e = 1; e <= 25; e++) begin
      run_mode = (e <= 3);
      if (e >= 10) btn = 1'b1;
      tick();
      chk("switch_step", 16'(step), 16'(pop_exp(e)));
      if (e == 5) chk("switch_div3", 16'(dut.div_cnt_q), 16'd3);
      if (e == 6) chk("switch_div0", 16'(dut.div_cnt_q), 16'd0);
    end
    exp_cnt++;
    chk("switch_cnt", step_cnt, exp_cnt);
    chk("switch_q", 16'(exp_q.size()), 16'd0);
    chk("switch_div_end", 16'(dut.div_cnt_q), 16'd0);
    btn = 1'b0;
    repeat (12) tick();

    // Reset at db_cnt = 2 in WAIT_PRESS with btn held
    btn = 1'b1;
    repeat (5) tick();
    chk("midrst_dbcnt", 16'(dut.db_cnt_q), 16'd2);
    rst = 1'b1;
    #1;
    chk("midrst_step", 16'(step), 16'd0);
    chk("midrst_level", 16'(btn_level), 16'd0);
    chk("midrst_run", 16'(run_active), 16'd0);
    chk("midrst_cnt", step_cnt, 16'd0);
    repeat (2) tick();
    rst = 1'b0;
    exp_q = '{8'd7};
    for (int e = 1; e <= 12; e++) begin
      tick();
      chk("postrst_step", 16'(step), 16'(pop_exp(e)));
      chk("postrst_level", 16'(btn_level), 16'(e >= 7));
    end
    exp_cnt = 16'd1;
    chk("postrst_cnt", step_cnt, exp_cnt);
    chk("postrst_q", 16'(exp_q.size()), 16'd0);
    btn = 1'b0;
    repeat (12) tick();

    // Counter wrap on the RUN_DIV=2 instance
    n = 0;
    while (step_cnt_w !== 16'hFFFF && n < 200000) begin
      @(negedge clk_w);
      n++;
    end
    chk("wrap_ffff", step_cnt_w, 16'hFFFF);
    n = 0;
    while (step_cnt_w === 16'hFFFF && n < 10) begin
      @(negedge clk_w);
      n++;
    end
    chk("wrap_zero", step_cnt_w, 16'h0000);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
